fifo_buffer: RTL and testbench

//  Circular-buffer storage and pointer datapath for the write-side FIFO. Accepts write beats, stores them
//  in a DEPTH-entry memory and returns them in order on read. Generates the full/empty status consumed by
//  the FIFO controller (which drives valid/ready), plus occupancy and error pulses. One clock domain.

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/fifo_mem.sv | 59 +++++
 rtl/fifo_buffer.sv | 133 +++++++++++++
 tb/tb_fifo_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the write-side FIFO: default geometry, the pointer
//   type and the full/empty pointer comparisons. The controller and the buffer
//   both call these functions, so they agree on what "full" and "empty" mean.
//
//   Pointers carry one extra wrap bit above the memory index:
//     empty : pointers identical
//     full  : index bits identical, wrap bits different
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF      = 8;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);

    // Pointer for the default geometry: index bits plus the wrap bit.
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

    // Width-generic helpers: pointers arrive zero-extended to 32 bits and aw
    // is the index width, so any power-of-two DEPTH can share them.
    function automatic logic ptr_empty(input logic [31:0] wp,
                                       input logic [31:0] rp,
                                       input int          aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return ((wp ^ rp) & mask) == 32'd0;
    endfunction

    function automatic logic ptr_full(input logic [31:0] wp,
                                      input logic [31:0] rp,
                                      input int          aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        // Only the wrap bit may differ.
        return ((wp ^ rp) & mask) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   Simple dual-port RAM: one synchronous write port and one registered read
//   port. The storage array is not reset; only the read data register is.
//
// Ports
//   clk    in   1            clock, rising edge
//   rst    in   1            synchronous reset, active high (read register only)
//   we     in   1            write enable
//   waddr  in   ADDR_WIDTH   write index
//   wdata  in   DATA_WIDTH   write data
//   re     in   1            read enable; rdata updates on the next edge
//   raddr  in   ADDR_WIDTH   read index
//   rdata  out  DATA_WIDTH   registered read data, holds when re is low
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Array has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_buffer.sv
// -----------------------------------------------------------------------------
// fifo_buffer
//   Circular-buffer storage and pointer datapath for the write-side FIFO.
//   Stores write beats in a DEPTH-entry memory and returns them in order.
//   Provides full/empty to the controller, plus occupancy and error pulses.
//
// Ports
//   clk     in   1             clock, rising edge
//   rst     in   1             synchronous reset, active high; wins over requests
//   wen     in   1             write request
//   wdata   in   DATA_WIDTH    write data, sampled when the write is accepted
//   ren     in   1             read request
//   rdata   out  DATA_WIDTH    registered read data
//   rvalid  out  1             rdata holds a word popped on the previous edge
//   full    out  1             DEPTH words stored
//   empty   out  1             no words stored
//   count   out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//   wr_err  out  1             one-cycle pulse: wen seen while full (write dropped)
//   rd_err  out  1             one-cycle pulse: ren seen while empty (read ignored)
//
// Request semantics: wen/ren are requests, full/empty are the matching
// not-ready indications. A write is accepted on an edge where wen && !full,
// a read on an edge where ren && !empty; requests that are not accepted are
// dropped (not held) and flagged by wr_err/rd_err on the following cycle.
// full/empty come from registered pointers, so a write into an empty FIFO is
// never read through in the same cycle.
// -----------------------------------------------------------------------------
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_err,
    output logic                  rd_err
);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rvalid_q, rvalid_d;
    logic                wr_err_q, wr_err_d;
    logic                rd_err_q, rd_err_d;

    logic                wr_acc;
    logic                rd_acc;
    logic                full_w;
    logic                empty_w;

    assign full_w  = ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);
    assign empty_w = ptr_empty(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);

    always_comb begin
        wr_acc   = wen && !full_w;
        rd_acc   = ren && !empty_w;

        // Pointer width is ADDR_WIDTH+1, so the increment wraps mod 2*DEPTH
        // and toggles the wrap bit when the index rolls over.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        rvalid_d = rd_acc;
        wr_err_d = wen && full_w;
        rd_err_d = ren && empty_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Memory ports are gated with rst so a reset edge neither stores a word
    // nor updates rdata from stale storage.
    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc && !rst),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .re    (rd_acc && !rst),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (rdata)
    );

    assign rvalid = rvalid_q;
    assign full   = full_w;
    assign empty  = empty_w;
    assign count  = count_q;
    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;

endmodule

// File: tb/tb_fifo_buffer.sv
// -----------------------------------------------------------------------------
// tb_fifo_buffer
//   Self-checking bench for fifo_buffer (DATA_WIDTH=16, DEPTH=8).
//   Reference model: a queue of stored words plus totals of accepted writes
//   and reads; expected outputs are derived from the queue size and contents.
// -----------------------------------------------------------------------------
module tb_fifo_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          rvalid, full, empty, wr_err, rd_err;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .wdata  (wdata),
        .ren    (ren),
        .rdata  (rdata),
        .rvalid (rvalid),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .wr_err (wr_err),
        .rd_err (rd_err)
    );

    // ---------------- scoreboard / model ----------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rdata  = '0;
    logic          exp_rvalid = 1'b0;
    logic          exp_wr_err = 1'b0;
    logic          exp_rd_err = 1'b0;
    int            wr_total   = 0;
    int            rd_total   = 0;
    int            checks     = 0;
    int            failures   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model advance for one clock edge, using the state before the edge.
    task automatic model_edge(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        if (r) begin
            exp_q.delete();
            exp_rdata  = '0;
            exp_rvalid = 1'b0;
            exp_wr_err = 1'b0;
            exp_rd_err = 1'b0;
            wr_total   = 0;
            rd_total   = 0;
        end else begin
            bit was_full;
            bit was_empty;
            was_full   = (exp_q.size() == DEPTH);
            was_empty  = (exp_q.size() == 0);
            exp_wr_err = w && was_full;
            exp_rd_err = rd && was_empty;
            exp_rvalid = rd && !was_empty;
            if (exp_rvalid) begin
                exp_rdata = exp_q.pop_front();
                rd_total++;
            end
            if (w && !was_full) begin
                exp_q.push_back(d);
                wr_total++;
            end
        end
    endtask

    task automatic check_model();
        chk("count",  32'(count),  32'(exp_q.size()));
        chk("empty",  32'(empty),  32'(exp_q.size() == 0));
        chk("full",   32'(full),   32'(exp_q.size() == DEPTH));
        chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
        chk("rdata",  32'(rdata),  32'(exp_rdata));
        chk("wr_err", 32'(wr_err), 32'(exp_wr_err));
        chk("rd_err", 32'(rd_err), 32'(exp_rd_err));
        chk("wr_ptr", 32'(dut.wr_ptr_q), 32'(wr_total % (2 * DEPTH)));
        chk("rd_ptr", 32'(dut.rd_ptr_q), 32'(rd_total % (2 * DEPTH)));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic w, input logic [DW-1:0] d, input logic rd);
        rst   = r;
        wen   = w;
        wdata = d;
        ren   = rd;
        @(posedge clk);
        #1;
        model_edge(r, w, d, rd);
        check_model();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, wen, ren;
        logic [DW-1:0] wdata;
        logic [AW:0]   count;
        logic          empty, full, rvalid;
        logic [DW-1:0] rdata;
        logic          wr_err, rd_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // rst wen ren wdata | count empty full rvalid rdata wr_err rd_err
        vecs[0] = '{1'b1, 1'b1, 1'b1, 16'h1111, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h2222, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h00A1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h00A2, 4'd1, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 16'h00A2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h00A3, 4'd1, 1'b0, 1'b0, 1'b0, 16'h00A2, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd1, 1'b0, 1'b0, 1'b0, 16'h00A2, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 16'h00A3, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 16'h00A3, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].wen, vecs[i].wdata, vecs[i].ren);
            chk("vec_count",  32'(count),  32'(vecs[i].count));
            chk("vec_empty",  32'(empty),  32'(vecs[i].empty));
            chk("vec_full",   32'(full),   32'(vecs[i].full));
            chk("vec_rvalid", 32'(rvalid), 32'(vecs[i].rvalid));
            chk("vec_rdata",  32'(rdata),  32'(vecs[i].rdata));
            chk("vec_wr_err", 32'(wr_err), 32'(vecs[i].wr_err));
            chk("vec_rd_err", 32'(rd_err), 32'(vecs[i].rd_err));
        end

        // ---- fill / drain, overflow, underflow ----
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_count", 32'(count), 32'd8);
        step(1'b0, 1'b1, 16'hDEAD, 1'b0);
        chk("ovf_wr_err", 32'(wr_err), 32'd1);
        chk("ovf_count",  32'(count),  32'd8);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("ovf_pulse_len", 32'(wr_err), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            chk("drain_rvalid", 32'(rvalid), 32'd1);
            chk("drain_rdata",  32'(rdata),  32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("udf_rd_err", 32'(rd_err), 32'd1);
        chk("udf_rvalid", 32'(rvalid), 32'd0);

        // ---- simultaneous at count 4, then at full and empty ----
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
        for (int i = 4; i < 14; i++) begin
            step(1'b0, 1'b1, DW'(16'h0100 + i), 1'b1);
            chk("sim_count", 32'(count), 32'd4);
            chk("sim_order", 32'(rdata), 32'(16'h0100 + i - 4));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'(16'h0200 + i), 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("simfull_count",  32'(count),  32'd7);
        chk("simfull_wr_err", 32'(wr_err), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 16'h0C0C, 1'b1);
        chk("simempty_count",  32'(count),  32'd1);
        chk("simempty_rd_err", 32'(rd_err), 32'd1);
        chk("simempty_rvalid", 32'(rvalid), 32'd0);

        // ---- wrap: three full fill/drain rounds ----
        step(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, DW'(k * DEPTH + i + 1), 1'b0);
            chk("wrap_bit", 32'(dut.wr_ptr_q[AW]), 32'((k + 1) & 1));
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b0, 1'b0, '0, 1'b1);
                chk("wrap_data", 32'(rdata), 32'(k * DEPTH + i + 1));
            end
        end

        // ---- reset mid-stream ----
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, DW'(16'h0300 + i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("mid_count5", 32'(count),  32'd5);
        chk("mid_rvalid", 32'(rvalid), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("mid_rst_empty",  32'(empty),  32'd1);
        chk("mid_rst_count",  32'(count),  32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        step(1'b0, 1'b1, 16'h00AA, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("mid_new_rdata", 32'(rdata), 32'h00AA);

        // ---- randomized traffic with drifting write/read bias ----
        for (int i = 0; i < 2000; i++) begin
            int bias;
            bias = ((i / 100) % 3 == 0) ? 75 : (((i / 100) % 3 == 1) ? 25 : 50);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < bias),
                 DW'($urandom),
                 ($urandom_range(0, 99) < (100 - bias)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
